// File: rtl/ifetch_if.sv
// ifetch_if: instruction-memory and decoder-side bus of the fetch stage
interface ifetch_if #(parameter int PC_W = 10);
    logic [PC_W-1:0] imem_addr;
    logic [19:0] imem_data;
    logic [19:0] inst;
    logic [4:0] op;
    logic valid;
    logic [PC_W-1:0] pc_out;
    logic stall;
    logic br_taken;
    logic [14:0] br_amt;
    modport master(output imem_addr, inst, op, valid, pc_out, input imem_data, stall, br_taken, br_amt);
    modport slave(input imem_addr, inst, op, valid, pc_out, output imem_data, stall, br_taken, br_amt);
endinterface

// File: rtl/ifetch.sv
// ifetch: program counter, sync-read imem fetch, relative branch and halt
module ifetch #(
    parameter int PC_W = 10,
    parameter logic [4:0] HALT_OP = 5'd31
) (
    input logic clk,
    input logic reset,
    input logic start,
    input logic [PC_W-1:0] start_pc,
    output logic done,
    ifetch_if.master b
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t state, state_n;
    logic [PC_W-1:0] pc, pc_n, f_pc, f_pc_n, pc_out, pc_out_n;
    logic [19:0] inst, inst_n;
    logic f_vld, f_vld_n, valid, valid_n, done_n;
    logic adv, hit, br, squash, take;
    assign adv = state == RUN && !b.stall;
    assign hit = adv && valid && inst[19:15] == HALT_OP;
    assign br = adv && valid && b.br_taken && !hit;
    assign squash = br || hit;
    assign take = f_vld && !squash;
    // while stalled, re-read the pending word so imem_data is still valid on release
    assign b.imem_addr = (state == RUN && b.stall) ? f_pc : pc;
    assign b.inst = inst;
    assign b.op = inst[19:15];
    assign b.valid = valid;
    assign b.pc_out = pc_out;
    always_comb begin
        state_n = state;
        pc_n = pc;
        f_pc_n = f_pc;
        f_vld_n = f_vld;
        inst_n = inst;
        pc_out_n = pc_out;
        valid_n = valid;
        done_n = done;
        if (start) begin
            state_n = RUN;
            pc_n = start_pc;
            f_vld_n = 1'b0;
            valid_n = 1'b0;
            done_n = 1'b0;
        end else if (adv) begin
            state_n = hit ? HALT : RUN;
            pc_n = br ? pc_out + PC_W'($signed(b.br_amt)) : pc + 1'b1;
            f_pc_n = pc;
            f_vld_n = !squash;
            valid_n = take;
            inst_n = take ? b.imem_data : inst;
            pc_out_n = take ? f_pc : pc_out;
            done_n = hit;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc <= '0;
            f_pc <= '0;
            f_vld <= 1'b0;
            inst <= '0;
            pc_out <= '0;
            valid <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            f_pc <= f_pc_n;
            f_vld <= f_vld_n;
            inst <= inst_n;
            pc_out <= pc_out_n;
            valid <= valid_n;
            done <= done_n;
        end
    end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: table-driven check of fetch, stall, branch, halt, reset and wrap
module tb_ifetch;
    localparam int PC_W = 10;
    localparam int N = 30;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [PC_W-1:0] start_pc = '0;
    logic done;
    int total = 0;
    int bad = 0;
    ifetch_if #(.PC_W(PC_W)) b();
    ifetch #(.PC_W(PC_W), .HALT_OP(5'd31)) dut(
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .done(done), .b(b)
    );
    always #5 clk = ~clk;
    logic [19:0] mem [1 << PC_W];
    always @(posedge clk) b.imem_data <= mem[b.imem_addr];
    typedef struct {
        logic st;
        logic [PC_W-1:0] spc;
        logic stl;
        logic br;
        logic [14:0] amt;
        logic v;
        logic [PC_W-1:0] pc;
        logic [19:0] ins;
        logic [PC_W-1:0] addr;
        logic dn;
    } vec_t;
    vec_t tv [N];
    function automatic logic [19:0] w(int a);
        return (a == 4) ? 20'hF8004 : 20'(a + 1);
    endfunction
    function automatic vec_t mk(logic st, int spc, logic stl, logic br, logic [14:0] amt,
                                logic v, int pc, int addr, logic dn);
        vec_t r;
        r.st = st; r.spc = PC_W'(spc); r.stl = stl; r.br = br; r.amt = amt;
        r.v = v; r.pc = PC_W'(pc); r.ins = w(pc); r.addr = PC_W'(addr); r.dn = dn;
        return r;
    endfunction
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        for (int i = 0; i < (1 << PC_W); i++) mem[i] = w(i);
        b.stall = 1'b0;
        b.br_taken = 1'b0;
        b.br_amt = '0;
        //          st spc   stl br amt       v  pc    addr  dn
        tv[0]  = mk(1, 0,    0, 0, 15'd0,    0, 0,    0,    0);
        tv[1]  = mk(0, 0,    0, 0, 15'd0,    0, 0,    1,    0);
        tv[2]  = mk(0, 0,    0, 0, 15'd0,    1, 0,    2,    0);
        tv[3]  = mk(0, 0,    0, 0, 15'd0,    1, 1,    3,    0);
        tv[4]  = mk(0, 0,    1, 0, 15'd0,    1, 1,    2,    0);
        tv[5]  = mk(0, 0,    1, 0, 15'd0,    1, 1,    2,    0);
        tv[6]  = mk(0, 0,    1, 0, 15'd0,    1, 1,    2,    0);
        tv[7]  = mk(0, 0,    0, 0, 15'd0,    1, 2,    4,    0);
        tv[8]  = mk(0, 0,    0, 0, 15'd0,    1, 3,    5,    0);
        tv[9]  = mk(0, 0,    0, 0, 15'd0,    1, 4,    6,    0);
        tv[10] = mk(0, 0,    0, 1, 15'd5,    0, 0,    7,    1);
        tv[11] = mk(0, 0,    0, 0, 15'd0,    0, 0,    7,    1);
        tv[12] = mk(0, 0,    0, 0, 15'd0,    0, 0,    7,    1);
        tv[13] = mk(1, 5,    0, 0, 15'd0,    0, 0,    5,    0);
        tv[14] = mk(0, 0,    0, 0, 15'd0,    0, 0,    6,    0);
        tv[15] = mk(0, 0,    0, 0, 15'd0,    1, 5,    7,    0);
        tv[16] = mk(0, 0,    0, 1, 15'h7FFE, 0, 0,    3,    0);
        tv[17] = mk(0, 0,    0, 0, 15'd0,    0, 0,    4,    0);
        tv[18] = mk(0, 0,    0, 0, 15'd0,    1, 3,    5,    0);
        tv[19] = mk(1, 1020, 0, 0, 15'd0,    0, 0,    1020, 0);
        tv[20] = mk(0, 0,    0, 0, 15'd0,    0, 0,    1021, 0);
        tv[21] = mk(0, 0,    0, 0, 15'd0,    1, 1020, 1022, 0);
        tv[22] = mk(0, 0,    0, 1, 15'd10,   0, 0,    6,    0);
        tv[23] = mk(0, 0,    0, 0, 15'd0,    0, 0,    7,    0);
        tv[24] = mk(0, 0,    0, 0, 15'd0,    1, 6,    8,    0);
        tv[25] = mk(1, 1023, 0, 0, 15'd0,    0, 0,    1023, 0);
        tv[26] = mk(0, 0,    0, 1, 15'd5,    0, 0,    0,    0);
        tv[27] = mk(0, 0,    0, 0, 15'd0,    1, 1023, 1,    0);
        tv[28] = mk(0, 0,    0, 0, 15'd0,    1, 0,    2,    0);
        tv[29] = mk(0, 0,    0, 0, 15'd0,    1, 1,    3,    0);
        #12;
        chk("rst_inst", b.inst, 0);
        chk("rst_op", b.op, 0);
        chk("rst_valid", b.valid, 0);
        chk("rst_pc_out", b.pc_out, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", b.imem_addr, 0);
        reset = 1'b0;
        tick();
        chk("idle_valid", b.valid, 0);
        chk("idle_addr", b.imem_addr, 0);
        for (int i = 0; i < N; i++) begin
            start = tv[i].st;
            start_pc = tv[i].spc;
            b.stall = tv[i].stl;
            b.br_taken = tv[i].br;
            b.br_amt = tv[i].amt;
            tick();
            chk($sformatf("row%0d_valid", i), b.valid, tv[i].v);
            chk($sformatf("row%0d_addr", i), b.imem_addr, tv[i].addr);
            chk($sformatf("row%0d_done", i), done, tv[i].dn);
            if (tv[i].v) begin
                chk($sformatf("row%0d_inst", i), b.inst, tv[i].ins);
                chk($sformatf("row%0d_op", i), b.op, tv[i].ins[19:15]);
                chk($sformatf("row%0d_pc_out", i), b.pc_out, tv[i].pc);
            end
        end
        b.stall = 1'b0;
        b.br_taken = 1'b0;
        start = 1'b1;
        start_pc = PC_W'(5);
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid_pc_out", b.pc_out, 7);
        chk("mid_valid", b.valid, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_inst", b.inst, 0);
        chk("async_op", b.op, 0);
        chk("async_valid", b.valid, 0);
        chk("async_pc_out", b.pc_out, 0);
        chk("async_done", done, 0);
        chk("async_addr", b.imem_addr, 0);
        tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("post_rst_valid", b.valid, 0);
        chk("post_rst_addr", b.imem_addr, 0);
        start = 1'b1;
        start_pc = PC_W'(12);
        tick();
        start = 1'b0;
        chk("restart_addr", b.imem_addr, 12);
        repeat (2) tick();
        chk("restart_valid", b.valid, 1);
        chk("restart_pc_out", b.pc_out, 12);
        chk("restart_inst", b.inst, 20'h0000D);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage for the 20-bit, 5-bit-opcode core. It sits directly upstream of the instruction decoder and feeds it each cycle with `op` (the opcode, bits 19:15) and `inst` (the full 20-bit word). It owns the program counter and drives a synchronous-read instruction memory. It also applies relative branches using the decoder's 15-bit `bamt` field, and stops fetching on a halt opcode.

## Interface
- `PC_W`, default 10: program counter and instruction memory address width.
- `HALT_OP`, default 5'd31: opcode that ends execution.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  one-cycle pulse; begins or restarts execution at `start_pc`.
- `start_pc`  in  PC_W  first instruction address, sampled when `start` is high.
- `stall`  in  1  downstream hold; freezes the stage.
- `br_taken`  in  1  the instruction currently on `inst` is a taken branch.
- `br_amt`  in  15  signed branch offset (two's complement), relative to `pc_out`.
- `imem_addr`  out  PC_W  instruction memory read address.
- `imem_data`  in  20  memory read data; returns the word at the address presented in the previous cycle.
- `inst`  out  20  registered instruction word to the decoder.
- `op`  out  5  always equal to `inst[19:15]`.
- `valid`  out  1  `inst` holds a real, unsquashed instruction.
- `pc_out`  out  PC_W  address of the instruction on `inst`.
- `done`  out  1  a halt has been reached; stays high until the next `start`.

## Operation
- States: IDLE, RUN, HALT. Reset enters IDLE.
- Internal registers:
  - `pc`: next fetch address.
  - `f_vld`, `f_pc`: a fetch was issued last cycle, and its address.
- IDLE and HALT:
  - No fetches are issued.
  - `imem_addr` = `pc`.
  - `valid` = 0.
- Start:
  - `start` in any state: `pc` ← `start_pc`, `f_vld` ← 0, `valid` ← 0, `done` ← 0, state ← RUN.
  - This restart overrides stall, branch and halt in the same cycle.
- RUN, `stall` low:
  - `imem_addr` = `pc`.
  - On the edge: `pc` ← `pc`+1, `f_pc` ← `pc`, `f_vld` ← 1.
  - If `f_vld` is 1: `inst` ← `imem_data`, `pc_out` ← `f_pc`, `valid` ← 1.
  - If `f_vld` is 0: `valid` ← 0.
- RUN, `stall` high:
  - `pc`, `f_vld`, `f_pc`, `inst`, `pc_out` and `valid` all hold.
  - `imem_addr` = `f_pc`, so the memory re-reads the pending word and `imem_data` is still correct on release.
- Branch:
  - Sampled only when `valid`=1, `stall`=0, and `op` ≠ `HALT_OP`.
  - `pc` ← `pc_out` + sign-extended `br_amt`, truncated to PC_W bits (modulo 2^PC_W).
  - `f_vld` ← 0 and `valid` ← 0: the in-flight fetch and the word being latched are both squashed.
- Halt:
  - Triggered when `valid`=1, `stall`=0 and `op`=`HALT_OP`.
  - Next state: state ← HALT, `done` ← 1, `valid` ← 0, `f_vld` ← 0.
  - The halt word is presented to the decoder for exactly one valid cycle.
  - Halt wins over a simultaneous `br_taken`.
- PC arithmetic: `pc`+1 wraps from 2^PC_W−1 to 0. There is no error flag.
- `br_taken` is ignored whenever `valid`=0.

## Timing
- Reset values:
  - `inst` = 0, `op` = 0, `valid` = 0, `pc_out` = 0, `done` = 0.
  - `imem_addr` = 0, `pc` = 0, `f_vld` = 0, `f_pc` = 0.
  - State = IDLE.
- Reset asserted mid-run: outputs clear immediately (asynchronously). The stage remains in IDLE until a `start`.
- Start latency, with `start` high in cycle 0:
  - Cycle 1: `imem_addr` = `start_pc`.
  - Cycle 2: `imem_data` holds the word at `start_pc`.
  - Cycle 3: `valid`=1 with that word on `inst`.
- Throughput: one instruction per cycle while `stall` is low.
- Branch penalty, with `br_taken` in cycle k:
  - `valid`=0 in cycles k+1 and k+2.
  - Cycle k+3: the target word is on `inst` with `valid`=1.
- Stall: zero-cycle release. The cycle after `stall` falls, the stage advances exactly as if no stall had occurred.
- `done` rises in the cycle after the halt word is presented, and stays high through HALT.

## Test plan
- **Sequential fetch:** memory words 0–3 = 0x00001, 0x00002, 0x00003, 0x00004; `start` with `start_pc`=0 in cycle 0 → `valid` rises in cycle 3; `inst`/`pc_out` = (0x00001,0), (0x00002,1), (0x00003,2), (0x00004,3) on consecutive cycles.
- **Stall replay:** assert `stall` for 3 cycles while `inst`=word 1 → `inst`, `pc_out` and `valid` hold and `imem_addr`=2; after release the outputs are word 2 then word 3, with no word skipped or duplicated.
- **Branches:**
  - `br_taken` with `br_amt`=15'h7FFE (−2) at `pc_out`=5 → `valid`=0 for two cycles, then `pc_out`=3.
  - `br_amt`=+10 at `pc_out`=1020 with `PC_W`=10 → target `pc_out`=6 (wrap).
- **Halt:** word at address 4 has `op`=31 → it is presented once with `valid`=1; next cycle `done`=1 and `valid`=0; `imem_addr` stops advancing; a simultaneous `br_taken` is ignored.
- **Reset and restart:** assert `reset` mid-run (`pc_out`=7) → all outputs 0 asynchronously; then `start` with `start_pc`=12 → first valid `pc_out`=12 three cycles later; `start` during HALT clears `done`.
- **PC wrap:** `start_pc`=1023 with `PC_W`=10 → `pc_out` sequence 1023, 0, 1.
